matrix_loader: RTL and testbench

Byte-stream to Wishbone bridge that sits directly upstream of the 8x8 RGB matrix driver's register-file slave. It hunts for a sync byte, then assembles 32 payload bytes into eight 32-bit row words, packed nibble-per-pixel as 0bxRGB with column 0 in bits [31:28]. It writes each row word to the driver's register at address = row index as soon as that row is complete. The byte stream typically comes from a UART receiver.

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/matrix_loader.sv | 139 +++++++++++++
 tb/tb_matrix_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg : shared types and constants for the 8x8 RGB matrix blocks
// Revision   : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    RECV     = 2'd1,
    WRITE    = 2'd2,
    WAIT_ACK = 2'd3
  } loader_state_t;

  localparam int         MATRIX_ROWS       = 8;
  localparam int         MATRIX_COLS       = 8;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bit positions inside a 4-bit pixel nibble (0bxRGB)
  localparam int RED   = 2;
  localparam int GREEN = 1;
  localparam int BLUE  = 0;

endpackage

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
// matrix_loader : sync-framed byte stream to Wishbone row-register writer
// Revision      : 1.0
// ============================================================================
`default_nettype none

module matrix_loader
  import matrix_pkg::*;
#(
  parameter int         WB_DATA_WIDTH = 32,
  parameter int         REG_COUNT     = MATRIX_ROWS,
  parameter int         WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int         WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int         ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_ready,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [WB_SEL_WIDTH-1:0]  o_wb_sel,
  output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_stall,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_rdata,
  output logic                     o_frame_done,
  output logic                     o_error
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]          C_TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [WB_ADDR_WIDTH-1:0] C_ROW_LAST = WB_ADDR_WIDTH'(REG_COUNT - 1);

  loader_state_t            r_state;
  logic [WB_ADDR_WIDTH-1:0] r_row;
  logic [1:0]               r_byte_idx;
  logic [WB_DATA_WIDTH-9:0] r_word;
  logic [TO_W-1:0]          r_timeout;

  logic w_accept;
  logic w_complete;
  logic w_unused;

  assign o_ready    = (r_state == HUNT) || (r_state == RECV);
  assign w_accept   = i_valid && o_ready;
  // Ack coinciding with strobe acceptance completes the write immediately
  assign w_complete = ((r_state == WRITE) && !i_wb_stall && i_wb_ack) ||
                      ((r_state == WAIT_ACK) && i_wb_ack);
  assign w_unused   = ^i_wb_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HUNT;
      r_row        <= '0;
      r_byte_idx   <= 2'd0;
      r_word       <= '0;
      r_timeout    <= '0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_sel     <= '0;
      o_wb_wdata   <= '0;
      o_frame_done <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_accept && (i_data == SYNC_BYTE)) begin
            r_state    <= RECV;
            r_row      <= '0;
            r_byte_idx <= 2'd0;
            o_error    <= 1'b0;
          end
        end
        RECV: begin
          if (w_accept) begin
            r_word     <= {r_word[WB_DATA_WIDTH-17:0], i_data};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              o_wb_cyc   <= 1'b1;
              o_wb_stb   <= 1'b1;
              o_wb_we    <= 1'b1;
              o_wb_sel   <= '1;
              o_wb_addr  <= r_row;
              o_wb_wdata <= {r_word, i_data};
              r_state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!i_wb_stall) begin
            o_wb_stb  <= 1'b0;
            r_timeout <= '0;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!i_wb_ack) begin
            if (r_timeout == C_TO_LAST) begin
              o_wb_cyc <= 1'b0;
              o_wb_we  <= 1'b0;
              o_wb_sel <= '0;
              o_error  <= 1'b1;
              r_state  <= HUNT;
            end else begin
              r_timeout <= r_timeout + TO_W'(1);
            end
          end
        end
        default: r_state <= HUNT;
      endcase

      // Overrides the per-state updates above when a row write finishes
      if (w_complete) begin
        o_wb_cyc   <= 1'b0;
        o_wb_we    <= 1'b0;
        o_wb_sel   <= '0;
        r_byte_idx <= 2'd0;
        if (r_row == C_ROW_LAST) begin
          o_frame_done <= 1'b1;
          r_state      <= HUNT;
        end else begin
          r_row   <= r_row + WB_ADDR_WIDTH'(1);
          r_state <= RECV;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// tb_matrix_loader : directed self-checking bench for matrix_loader
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_loader;
  import matrix_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_ready;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_wdata;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_rdata;
  logic        o_frame_done, o_error;

  always #5 clk = ~clk;

  matrix_loader #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata), .i_wb_ack(i_wb_ack),
    .i_wb_stall(i_wb_stall), .i_wb_rdata(i_wb_rdata),
    .o_frame_done(o_frame_done), .o_error(o_error)
  );

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] exp;
  } row_vec_t;

  row_vec_t uni [8];
  row_vec_t mixed [8];
  row_vec_t tab [8];

  int total = 0;
  int bad   = 0;

  logic [2:0]  log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_sel  [$];
  logic        log_we   [$];
  int          done_cnt = 0;
  int          done_log_size = -1;
  int          no_ack_row = -1;

  // Slave model: logs each accepted strobe and acks it one cycle later
  logic       acc_next;
  logic [2:0] acc_addr;
  initial begin
    i_wb_ack = 1'b0;
    acc_addr = 3'd0;
    forever begin
      @(negedge clk);
      acc_next = o_wb_cyc && o_wb_stb && !i_wb_stall;
      if (acc_next) begin
        acc_addr = o_wb_addr;
        log_addr.push_back(o_wb_addr);
        log_data.push_back(o_wb_wdata);
        log_sel.push_back(o_wb_sel);
        log_we.push_back(o_wb_we);
      end
      if (o_frame_done) begin
        done_cnt++;
        done_log_size = log_addr.size();
      end
      @(posedge clk);
      #1;
      i_wb_ack = acc_next && (int'(acc_addr) != no_ack_row);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic row_vec_t mk(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d,
                                  input logic [31:0] e);
    row_vec_t r;
    r.b[0] = a; r.b[1] = b; r.b[2] = c; r.b[3] = d; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_valid = 1'b1;
    i_data  = b;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!o_ready) begin
      total++; bad++;
      $display("FAIL send_byte: o_ready stuck at %b, required 1", o_ready);
    end else begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic send_row(input int r);
    for (int j = 0; j < 4; j++) send_byte(tab[r].b[j]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_wb_cyc || !o_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL wait_idle: cyc=%b ready=%b, required 0/1", o_wb_cyc, o_ready);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_sel.delete(); log_we.delete();
    done_cnt = 0;
    done_log_size = -1;
  endtask

  task automatic send_frame();
    send_byte(DEFAULT_SYNC_BYTE);
    for (int r = 0; r < 8; r++) send_row(r);
    wait_idle();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nwrites"}, log_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), log_addr[i], i);
        check($sformatf("%s_data%0d", tag, i), log_data[i], tab[i].exp);
        check($sformatf("%s_sel%0d", tag, i), log_sel[i], 4'hf);
        check($sformatf("%s_we%0d", tag, i), log_we[i], 1);
      end
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_after_row7"}, done_log_size, 8);
  endtask

  logic [7:0] garbage [3];

  initial begin
    int n;
    reset = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_wb_stall = 1'b0; i_wb_rdata = 32'h0;
    for (int i = 0; i < 8; i++) uni[i] = mk(8'h12, 8'h34, 8'h56, 8'h71, 32'h12345671);
    mixed[0] = mk(8'hA5, 8'hA5, 8'hA5, 8'hA5, 32'hA5A5A5A5);
    mixed[1] = mk(8'h01, 8'h23, 8'h45, 8'h67, 32'h01234567);
    mixed[2] = mk(8'hFF, 8'h00, 8'hFF, 8'h00, 32'hFF00FF00);
    mixed[3] = mk(8'h89, 8'hAB, 8'hCD, 8'hEF, 32'h89ABCDEF);
    mixed[4] = mk(8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000);
    mixed[5] = mk(8'h0F, 8'h0E, 8'h0D, 8'h0C, 32'h0F0E0D0C);
    mixed[6] = mk(8'h77, 8'hA5, 8'h11, 8'hA5, 32'h77A511A5);
    mixed[7] = mk(8'h42, 8'h42, 8'h42, 8'h0F, 32'h4242420F);
    garbage[0] = 8'h00; garbage[1] = 8'hFF; garbage[2] = 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_we", o_wb_we, 0);
    check("rst_sel", o_wb_sel, 0);
    check("rst_addr", o_wb_addr, 0);
    check("rst_wdata", o_wb_wdata, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_error", o_error, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Uniform frame
    tab = uni;
    clear_log();
    send_frame();
    check_frame("uni");

    // Garbage before sync, then a frame with A5 bytes in the payload
    clear_log();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("garbage_ready%0d", g), o_ready, 1);
      send_byte(garbage[g]);
    end
    repeat (3) @(posedge clk);
    #1;
    check("garbage_nwrites", log_addr.size(), 0);
    check("garbage_cyc", o_wb_cyc, 0);
    tab = mixed;
    send_frame();
    check_frame("mixed");

    // Row 3 stalled for 5 cycles
    clear_log();
    send_byte(DEFAULT_SYNC_BYTE);
    for (int r = 0; r < 3; r++) send_row(r);
    for (int j = 0; j < 3; j++) send_byte(tab[3].b[j]);
    i_wb_stall = 1'b1;
    send_byte(tab[3].b[3]);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_stb%0d", k), o_wb_stb, 1);
      check($sformatf("stall_addr%0d", k), o_wb_addr, 3);
      check($sformatf("stall_wdata%0d", k), o_wb_wdata, 32'h89ABCDEF);
      check($sformatf("stall_ready%0d", k), o_ready, 0);
      @(posedge clk); #1;
    end
    i_wb_stall = 1'b0;
    for (int r = 4; r < 8; r++) send_row(r);
    wait_idle();
    check_frame("stall");

    // Row 2 never acked: timeout
    clear_log();
    no_ack_row = 2;
    send_byte(DEFAULT_SYNC_BYTE);
    for (int r = 0; r < 3; r++) send_row(r);
    n = 0;
    while (o_wb_cyc && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("timeout_cycles", n, 17);
    check("timeout_error", o_error, 1);
    check("timeout_ready", o_ready, 1);
    check("timeout_nwrites", log_addr.size(), 3);
    no_ack_row = -1;
    for (int j = 0; j < 4; j++) send_byte(8'h11 * (j + 1));
    repeat (3) @(posedge clk);
    #1;
    check("timeout_hunt_nwrites", log_addr.size(), 3);
    check("timeout_error_sticky", o_error, 1);
    clear_log();
    send_byte(DEFAULT_SYNC_BYTE);
    check("sync_clears_error", o_error, 0);
    for (int r = 0; r < 8; r++) send_row(r);
    wait_idle();
    check_frame("after_timeout");

    // Reset while strobing row 5
    tab = uni;
    clear_log();
    send_byte(DEFAULT_SYNC_BYTE);
    for (int r = 0; r < 5; r++) send_row(r);
    for (int j = 0; j < 3; j++) send_byte(tab[5].b[j]);
    i_wb_stall = 1'b1;
    send_byte(tab[5].b[3]);
    check("pre_reset_stb", o_wb_stb, 1);
    check("pre_reset_addr", o_wb_addr, 5);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_cyc", o_wb_cyc, 0);
    check("midrst_stb", o_wb_stb, 0);
    check("midrst_ready", o_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    i_wb_stall = 1'b0;
    @(posedge clk); #1;
    clear_log();
    tab = mixed;
    send_frame();
    check_frame("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
